// File: rtl/uart_port.sv
// Memory-mapped 8N1 UART in IO window 1. Contains a TX shifter, an RX shifter
// behind a 2-flop synchronizer, a small RX FIFO and a programmable baud divisor.
module uart_port #(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 433,
  parameter int RXF_LOG2  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        UART_WE,
  input  logic        UART_RE,
  input  logic [1:0]  UART_A,
  input  logic [31:0] UART_WD,
  output logic [31:0] UART_RD,
  input  logic        RXD,
  output logic        TXD
);
  localparam int DEPTH = 1 << RXF_LOG2;
  localparam logic [RXF_LOG2:0] FULL_CNT = (RXF_LOG2+1)'(DEPTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [DIV_W-1:0]    div_q, div_wr;
  logic [DIV_W:0]      div_p1;
  logic [DIV_W-1:0]    half_m1;
  logic [1:0]          tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [DIV_W-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]          tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]          tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic                txd_q, txd_d;
  logic                rx_s1_q, rx_s2_q, rx_last_q;
  logic [7:0]          mem_q [DEPTH];
  logic [RXF_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [RXF_LOG2:0]   cnt_q;
  logic                tx_ovr_q, ferr_q, rx_ovr_q;
  logic                wr_data, wr_stat, wr_div, rx_empty, rx_full, pop, push;
  logic                tx_ovr_set, rx_push_req, ferr_set, ovr_set, unused_ok;

  assign wr_data  = UART_WE && (UART_A == 2'd0);
  assign wr_stat  = UART_WE && (UART_A == 2'd1);
  assign wr_div   = UART_WE && (UART_A == 2'd2);
  assign rx_empty = (cnt_q == '0);
  assign rx_full  = (cnt_q == FULL_CNT);
  // Write wins over read if the decoder ever asserts both.
  assign pop      = UART_RE && !UART_WE && (UART_A == 2'd0) && !rx_empty;
  assign push     = rx_push_req && (!rx_full || pop);
  assign ovr_set  = rx_push_req && rx_full && !pop;
  assign div_wr   = (UART_WD[DIV_W-1:0] < DIV_W'(3)) ? DIV_W'(3) : UART_WD[DIV_W-1:0];
  assign div_p1   = {1'b0, div_q} + (DIV_W+1)'(1);
  assign half_m1  = div_p1[DIV_W:1] - DIV_W'(1);
  assign TXD      = txd_q;
  assign unused_ok = ^UART_WD;

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_ovr_set = wr_data && (tx_st_q != ST_IDLE);
    case (tx_st_q)
      ST_IDLE: if (wr_data) begin
        tx_st_d  = ST_START;
        tx_cnt_d = div_q;
        tx_sh_d  = UART_WD[7:0];
        txd_d    = 1'b0;
      end
      ST_START: if (tx_cnt_q == '0) begin
        tx_st_d  = ST_DATA;
        tx_cnt_d = div_q;
        tx_bit_d = 3'd0;
        txd_d    = tx_sh_q[0];
      end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      ST_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = div_q;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7) begin
          tx_st_d = ST_STOP;
          txd_d   = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          txd_d    = tx_sh_q[1];
        end
      end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      default: if (tx_cnt_q == '0) tx_st_d = ST_IDLE;
               else tx_cnt_d = tx_cnt_q - DIV_W'(1);
    endcase
  end

  // RX samples the synchronized line at mid-bit; STOP returns to IDLE at mid-stop.
  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push_req = 1'b0;
    ferr_set    = 1'b0;
    case (rx_st_q)
      ST_IDLE: if (rx_last_q && !rx_s2_q) begin
        rx_st_d  = ST_START;
        rx_cnt_d = half_m1;
      end
      ST_START: if (rx_cnt_q == '0) begin
        rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
        rx_cnt_d = div_q;
        rx_bit_d = 3'd0;
      end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
      ST_DATA: if (rx_cnt_q == '0) begin
        rx_cnt_d = div_q;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
      default: if (rx_cnt_q == '0) begin
        rx_st_d     = ST_IDLE;
        rx_push_req = rx_s2_q;
        ferr_set    = !rx_s2_q;
      end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q     <= DIV_W'(DIV_RESET);
      tx_st_q   <= ST_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      txd_q     <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_last_q <= 1'b1;
      rx_st_q   <= ST_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tx_ovr_q  <= 1'b0;
      ferr_q    <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      if (wr_div) div_q <= div_wr;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      txd_q     <= txd_d;
      rx_s1_q   <= RXD;
      rx_s2_q   <= rx_s1_q;
      rx_last_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      // A new event in the same cycle as a clear keeps the flag set.
      tx_ovr_q <= (tx_ovr_q && !(wr_stat && UART_WD[5])) || tx_ovr_set;
      ferr_q   <= (ferr_q   && !(wr_stat && UART_WD[4])) || ferr_set;
      rx_ovr_q <= (rx_ovr_q && !(wr_stat && UART_WD[3])) || ovr_set;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= rx_sh_q;
  end

  always_comb begin
    UART_RD = '0;
    case (UART_A)
      2'd0: if (!rx_empty) UART_RD[7:0] = mem_q[rd_ptr_q];
      2'd1: UART_RD[5:0] = {tx_ovr_q, ferr_q, rx_ovr_q, rx_full, !rx_empty, tx_st_q != ST_IDLE};
      2'd2: UART_RD = 32'(div_q);
      default: UART_RD = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_port.sv
// Bench for uart_port: directed and random frames against a byte-level model
// of the serial line, RX FIFO contents and sticky status flags.
module tb_uart_port;
  logic        CLK = 1'b0;
  logic        RESET, UART_WE, UART_RE, RXD, TXD;
  logic [1:0]  UART_A;
  logic [31:0] UART_WD, UART_RD;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic exp_txovr, exp_rxovr, exp_ferr;
  logic [31:0] d;
  logic [7:0]  b;
  int dv;

  uart_port dut (
    .CLK(CLK), .RESET(RESET), .UART_WE(UART_WE), .UART_RE(UART_RE),
    .UART_A(UART_A), .UART_WD(UART_WD), .UART_RD(UART_RD),
    .RXD(RXD), .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] wd);
    @(negedge CLK);
    UART_WE = 1'b1; UART_A = a; UART_WD = wd;
    @(negedge CLK);
    UART_WE = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic rd_pop, output logic [31:0] rd);
    @(negedge CLK);
    UART_A = a; UART_RE = rd_pop;
    #1 rd = UART_RD;
    @(negedge CLK);
    UART_RE = 1'b0;
  endtask

  // Drives one 8N1 frame, bc clocks per bit, then idles the line.
  task automatic send_rx(input logic [7:0] sb, input logic stop_b, input int bc);
    logic [9:0] fr;
    fr = {stop_b, sb, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RXD = fr[k];
      repeat (bc) @(negedge CLK);
    end
    RXD = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic model_rx(input logic [7:0] mb, input logic stop_b);
    if (!stop_b) exp_ferr = 1'b1;
    else if (exp_q.size() < 4) exp_q.push_back(mb);
    else exp_rxovr = 1'b1;
  endtask

  function automatic logic [31:0] status_exp(input logic busy);
    logic [5:0] s;
    s = {exp_txovr, exp_ferr, exp_rxovr, exp_q.size() == 4, exp_q.size() != 0, busy};
    return {26'b0, s};
  endfunction

  task automatic pop_check(input string tag);
    logic [31:0] rd;
    logic [7:0] e;
    reg_read(2'd0, 1'b1, rd);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk(tag, rd, {24'b0, e});
  endtask

  task automatic status_check(input string tag);
    logic [31:0] rd;
    reg_read(2'd1, 1'b0, rd);
    chk(tag, rd, status_exp(1'b0));
  endtask

  // Checks every bit period of one TX frame; optionally writes again mid-frame.
  task automatic tx_check(input logic [7:0] tb, input int div, input int inject);
    int bt, k;
    logic eb;
    bt = div + 1;
    reg_write(2'd0, {24'b0, tb});
    UART_A = 2'd1;
    for (int i = 0; i < 10 * bt; i++) begin
      #1;
      k = i / bt;
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tb[k-1];
      chk("tx_bit", {31'b0, TXD}, {31'b0, eb});
      if (!(inject >= 0 && i == inject + 1)) chk("tx_busy", {31'b0, UART_RD[0]}, 32'd1);
      if (i == inject) begin
        UART_WE = 1'b1; UART_A = 2'd0; UART_WD = 32'hFF;
        exp_txovr = 1'b1;
      end else begin
        UART_WE = 1'b0; UART_A = 2'd1;
      end
      @(negedge CLK);
    end
    UART_WE = 1'b0; UART_A = 2'd1;
    #1;
    chk("tx_end_txd", {31'b0, TXD}, 32'd1);
    chk("tx_end_busy", {31'b0, UART_RD[0]}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; UART_WE = 1'b0; UART_RE = 1'b0; UART_A = 2'd0; UART_WD = '0; RXD = 1'b1;
    exp_txovr = 1'b0; exp_rxovr = 1'b0; exp_ferr = 1'b0;
    repeat (3) @(negedge CLK);
    chk("txd_in_reset", {31'b0, TXD}, 32'd1);
    RESET = 1'b0;

    reg_read(2'd0, 1'b0, d); chk("rst_data", d, 32'd0);
    reg_read(2'd1, 1'b0, d); chk("rst_status", d, 32'd0);
    reg_read(2'd2, 1'b0, d); chk("rst_div", d, 32'd433);
    reg_read(2'd3, 1'b0, d); chk("rst_a3", d, 32'd0);
    chk("rst_txd", {31'b0, TXD}, 32'd1);

    reg_write(2'd2, 32'd1);          reg_read(2'd2, 1'b0, d); chk("div_clamp", d, 32'd3);
    reg_write(2'd2, 32'h0001_0005);  reg_read(2'd2, 1'b0, d); chk("div_width", d, 32'd5);
    reg_write(2'd3, 32'hFFFF_FFFF);  reg_read(2'd3, 1'b0, d); chk("a3_write", d, 32'd0);
    reg_write(2'd2, 32'd3);

    tx_check(8'hA5, 3, 10);
    status_check("tx_ovr_set");
    reg_write(2'd1, 32'h20); exp_txovr = 1'b0;
    status_check("tx_ovr_clr");

    send_rx(8'h3C, 1'b1, 4); model_rx(8'h3C, 1'b1);
    status_check("rx_nonempty");
    pop_check("rx_3c");
    status_check("rx_drained");

    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i), 1'b1, 4); model_rx(8'(i), 1'b1);
    end
    status_check("rx_full_ovr");
    for (int i = 0; i < 5; i++) pop_check("fifo_drain");
    reg_write(2'd1, 32'h08); exp_rxovr = 1'b0;
    status_check("ovr_clr");
    send_rx(8'h5A, 1'b1, 4); model_rx(8'h5A, 1'b1);
    pop_check("ptr_after_empty_pop");

    RXD = 1'b0; @(negedge CLK); RXD = 1'b1;
    repeat (20) @(negedge CLK);
    status_check("false_start");
    send_rx(8'h81, 1'b0, 4); model_rx(8'h81, 1'b0);
    status_check("frame_err");
    reg_write(2'd1, 32'h10); exp_ferr = 1'b0;
    status_check("ferr_clr");

    send_rx(8'h77, 1'b1, 4); model_rx(8'h77, 1'b1);
    @(negedge CLK);
    UART_WE = 1'b1; UART_RE = 1'b1; UART_A = 2'd0; UART_WD = 32'h33;
    @(negedge CLK);
    UART_WE = 1'b0; UART_RE = 1'b0; UART_A = 2'd1;
    #1 chk("we_re_status", UART_RD, status_exp(1'b1));
    repeat (45) @(negedge CLK);
    pop_check("we_re_no_pop");

    for (int r = 0; r < 4; r++) begin
      dv = $urandom_range(3, 6);
      reg_write(2'd2, dv);
      b = 8'($urandom_range(0, 255));
      tx_check(b, dv, -1);
      b = 8'($urandom_range(0, 255));
      send_rx(b, 1'b1, dv + 1); model_rx(b, 1'b1);
      pop_check("rand_rx");
      status_check("rand_status");
    end

    reg_write(2'd2, 32'd3);
    reg_write(2'd0, 32'h00);
    RXD = 1'b0;
    repeat (6) @(negedge CLK);
    chk("tx_mid_frame", {31'b0, TXD}, 32'd0);
    #3 RESET = 1'b1;
    #1 chk("txd_async_reset", {31'b0, TXD}, 32'd1);
    exp_q.delete(); exp_txovr = 1'b0; exp_rxovr = 1'b0; exp_ferr = 1'b0;
    RXD = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    status_check("post_reset_status");
    pop_check("post_reset_empty");
    reg_read(2'd2, 1'b0, d); chk("post_reset_div", d, 32'd433);
    reg_write(2'd2, 32'd3);
    b = 8'($urandom_range(0, 255));
    tx_check(b, 3, -1);
    b = 8'($urandom_range(0, 255));
    send_rx(b, 1'b1, 4); model_rx(b, 1'b1);
    pop_check("post_reset_rx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_port.md
Name: uart_port

Overview:
- Memory-mapped 8N1 UART that sits directly downstream of the IO address decoder and occupies IO window 1 (addr[7:4]=1).
- Consumes the decoder's registered UART_WE/UART_RE/UART_A/UART_WD strobes and returns UART_RD to the read mux.
- Contains a TX shifter, an RX shifter with an input synchronizer, a small RX FIFO and a programmable baud divisor.

Parameters:
- DIV_W, 16, width of the baud divisor register.
- DIV_RESET, 433, divisor value loaded at reset; bit period is DIV+1 clocks (50 MHz / 115200).
- RXF_LOG2, 2, log2 of RX FIFO depth (default 4 entries).

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- UART_WE  in  1  register write strobe, single-cycle, qualified by decoder
- UART_RE  in  1  register read strobe, single-cycle; pops RX FIFO when A=0
- UART_A  in  2  register select
- UART_WD  in  32  write data
- UART_RD  out  32  read data, combinational from UART_A and current state
- RXD  in  1  serial input, asynchronous to CLK
- TXD  out  1  serial output

Behaviour:
- Register map (UART_RD unused bits read 0):
  - A=0 DATA. Write: WD[7:0] starts a TX frame if TX is idle. A write while TX is busy is dropped and sets tx_ovr. Read: RX FIFO head in [7:0]; returns 0 if empty. UART_RE pops the head at the clock edge (no pop when empty).
  - A=1 STATUS. [0] tx_busy, [1] rx_nonempty, [2] rx_full, [3] rx_ovr, [4] frame_err, [5] tx_ovr. Bits 3-5 are sticky. A write clears each sticky bit whose WD bit is 1.
  - A=2 DIV. R/W, DIV_W bits. Writes below 3 are stored as 3. The new value takes effect at the next bit-counter reload; software writes it only while both TX and RX are idle.
  - A=3: reads 0, writes ignored.
- Reset values: TXD=1, DIV=DIV_RESET, FIFO empty, all status bits 0, both FSMs in IDLE, RX synchronizer flops=1.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state holds TXD for DIV+1 clocks.
  - tx_busy asserts the cycle after the accepted write and deasserts when STOP ends: 10*(DIV+1) cycles total.
  - A new write accepted in the cycle tx_busy is low starts the next frame with no gap beyond that.
- RX FSM: 2-flop synchronizer on RXD (2-cycle latency), then IDLE -> START -> DATA -> STOP.
  - IDLE: a synced 1->0 transition enters START and loads a half-bit count floor((DIV+1)/2).
  - START: at mid-bit, sample. If 1, it is a false start: return to IDLE, no status change. If 0, go to DATA.
  - DATA: sample every DIV+1 clocks, 8 samples, LSB first.
  - STOP: sample at mid-stop.
    - 1 and FIFO not full: push byte.
    - 1 and FIFO full: drop byte, set rx_ovr.
    - 0: discard byte, set frame_err.
  - Return to IDLE at mid-stop, so the next start edge can be accepted immediately.
- FIFO: a push and pop in the same cycle both take effect; count is unchanged. This holds when full, and the push is not an overrun in that case. Pointers wrap modulo depth. rx_full means count == depth.
- Reset mid-frame: both FSMs abort immediately, TXD returns to 1 asynchronously, and the partial RX byte is lost.
- UART_WE and UART_RE are never asserted together by the decoder. If they are, the write takes precedence and no pop occurs.

Test Plan:
1. Reset, then read A=0/1/2 -> 0, 0, 433; TXD=1 throughout.
2. DIV=3; write 0xA5 to A=0 -> TXD is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. tx_busy is high for 40 cycles. A second write at cycle 10 is dropped and sets STATUS[5]; write 0x20 to A=1 clears it.
3. DIV=3; drive 0x3C on RXD at 4 clocks/bit -> STATUS[1]=1 about 2+38 cycles after the start edge. Read A=0 with RE gives 0x3C; a following STATUS read gives [1]=0.
4. Send 5 bytes 0x01..0x05 without reading -> STATUS[2]=1 and [3]=1. Four reads return 0x01..0x04; a fifth read returns 0 with no pointer change.
5. A 1-cycle RXD low glitch gives a false start (no push, no status change). A frame with stop bit 0 sets STATUS[4] and pushes nothing.
6. Assert RESET halfway through a TX frame and an RX frame -> TXD=1 immediately. After release, the FIFO is empty and a fresh frame transmits and receives correctly.
